// File: rtl/mul_div_unit.sv
// Iterative MULTU/DIVU unit with HI/LO registers and MTHI/MTLO writes; one result bit per cycle.
// Optional signed MULT/DIV support is compiled in when MDU_SIGNED_EN is defined.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_a_orig;
    logic               r_is_div;
    logic               r_dbz;
    logic               r_neg_q;
    logic               r_neg_r;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_neg_q;
    logic               w_neg_r;

`ifdef MDU_SIGNED_EN
    logic w_a_neg;
    logic w_b_neg;
    assign w_a_neg = sgn & a[WIDTH-1];
    assign w_b_neg = sgn & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;
    assign w_neg_q = w_a_neg ^ w_b_neg;
    assign w_neg_r = w_a_neg;
`else
    logic w_unused_sgn;
    assign w_unused_sgn = sgn;
    assign w_a_mag = a;
    assign w_b_mag = b;
    assign w_neg_q = 1'b0;
    assign w_neg_r = 1'b0;
`endif

    // Shift-add: upper half accumulates, lower half shifts the multiplier out.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: upper half is the partial remainder, lower half dividend/quotient.
    logic [WIDTH:0]     w_div_sh;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;
    assign w_div_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge   = w_div_sh >= {1'b0, r_opnd};
    assign w_div_diff = w_div_sh[WIDTH-1:0] - r_opnd;
    assign w_div_next = w_div_ge ? {w_div_diff, r_acc[WIDTH-2:0], 1'b1}
                                 : {w_div_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    logic [2*WIDTH-1:0] w_prod_res;
    logic [WIDTH-1:0]   w_quo_res;
    logic [WIDTH-1:0]   w_rem_res;
    assign w_prod_res = r_neg_q ? -r_acc : r_acc;
    assign w_quo_res  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_res  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_opnd      <= '0;
            r_a_orig    <= '0;
            r_is_div    <= 1'b0;
            r_dbz       <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            2'b00: begin
                                r_acc    <= {{WIDTH{1'b0}}, w_b_mag};
                                r_opnd   <= w_a_mag;
                                r_is_div <= 1'b0;
                                r_dbz    <= 1'b0;
                                r_neg_q  <= w_neg_q;
                                r_neg_r  <= 1'b0;
                                r_cnt    <= '0;
                                busy     <= 1'b1;
                                r_state  <= S_MUL;
                            end
                            2'b01: begin
                                r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                                r_opnd   <= w_b_mag;
                                r_a_orig <= a;
                                r_is_div <= 1'b1;
                                r_dbz    <= (b == '0);
                                r_neg_q  <= w_neg_q;
                                r_neg_r  <= w_neg_r;
                                r_cnt    <= '0;
                                busy     <= 1'b1;
                                r_state  <= S_DIV;
                            end
                            2'b10: begin
                                hi          <= a;
                                done        <= 1'b1;
                                div_by_zero <= 1'b0;
                            end
                            default: begin
                                lo          <= a;
                                done        <= 1'b1;
                                div_by_zero <= 1'b0;
                            end
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    r_acc <= (r_state == S_MUL) ? w_mul_next : w_div_next;
                    if (r_cnt == LAST) begin
                        busy    <= 1'b0;
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_FIN: begin
                    done        <= 1'b1;
                    div_by_zero <= r_dbz;
                    r_cnt       <= '0;
                    r_state     <= S_IDLE;
                    if (!r_is_div) begin
                        {hi, lo} <= w_prod_res;
                    end else if (r_dbz) begin
                        hi <= r_a_orig;
                        lo <= '1;
                    end else begin
                        hi <= w_rem_res;
                        lo <= w_quo_res;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed scoreboard bench for mul_div_unit: results queued at start, compared at done.
module tb_mul_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        sb[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .sgn(sgn), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done === 1'b1) n++;
        end
    endtask

    task automatic run_op(input logic [1:0] t_op, input logic t_sgn,
                          input logic [31:0] t_a, input logic [31:0] t_b,
                          input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_dbz,
                          input int repulse_at, input int rst_at);
        exp_t r;
        int   edges;
        int   busy_cyc;
        int   extra;
        bit   aborted;
        r.hi = e_hi; r.lo = e_lo; r.dbz = e_dbz;
        sb.push_back(r);
        op = t_op; sgn = t_sgn; a = t_a; b = t_b; start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom; b = $urandom;
        edges = 0; busy_cyc = 0; aborted = 0;
        while (done !== 1'b1 && edges < 100) begin
            if (busy === 1'b1) busy_cyc++;
            if (edges == 16) begin
                chk("hold_hi", {32'd0, hi}, {32'd0, m_hi});
                chk("hold_lo", {32'd0, lo}, {32'd0, m_lo});
            end
            if (edges == repulse_at) begin
                op = 2'b01; a = 32'd9; b = 32'd3; start = 1'b1;
            end
            if (edges == rst_at) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_busy", {63'd0, busy}, 64'd0);
                chk("rst_hi_lo", {hi, lo}, 64'd0);
                #1 rst = 1'b0;
                aborted = 1;
                break;
            end
            tick();
            start = 1'b0;
            edges++;
        end
        r = sb.pop_front();
        if (aborted) begin
            m_hi = '0; m_lo = '0;
            count_dones(40, extra);
            chk("abort_no_done", 64'(extra), 64'd0);
        end else if (edges >= 100) begin
            chk("done_timeout", {63'd0, done}, 64'd1);
        end else begin
            chk("hi", {32'd0, hi}, {32'd0, r.hi});
            chk("lo", {32'd0, lo}, {32'd0, r.lo});
            chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, r.dbz});
            chk("busy_at_done", {63'd0, busy}, 64'd0);
            chk("latency", 64'(edges), t_op[1] ? 64'd0 : 64'd33);
            chk("busy_cycles", 64'(busy_cyc), t_op[1] ? 64'd0 : 64'd32);
            m_hi = r.hi; m_lo = r.lo;
            tick();
            chk("done_pulse", {63'd0, done}, 64'd0);
            if (repulse_at >= 0) begin
                count_dones(40, extra);
                chk("single_done", 64'(extra), 64'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] prod;
        rst = 1'b1; start = 1'b0; op = 2'b00; sgn = 1'b0; a = '0; b = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_dbz", {63'd0, div_by_zero}, 64'd0);
        chk("reset_hi_lo", {hi, lo}, 64'd0);

        run_op(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, -1, -1);
        run_op(2'b01, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, -1, -1);
        run_op(2'b01, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, -1, -1);
        run_op(2'b10, 1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, -1, -1);
        run_op(2'b11, 1'b0, 32'h9ABC_DEF0, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, -1, -1);
        run_op(2'b00, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 5, -1);
        run_op(2'b01, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, -1, 10);
        run_op(2'b00, 1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, -1, -1);
        run_op(2'b01, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, -1, -1);

`ifdef MDU_SIGNED_EN
        run_op(2'b01, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1, -1);
        run_op(2'b00, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, -1, -1);
        run_op(2'b01, 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, -1, -1);
`else
        run_op(2'b01, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0, -1, -1);
        run_op(2'b00, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'd4, 32'hFFFF_FFF1, 1'b0, -1, -1);
`endif

        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom;
            prod = {32'd0, ra} * {32'd0, rb};
            run_op(2'b00, 1'b0, ra, rb, prod[63:32], prod[31:0], 1'b0, -1, -1);
            rb = (i < 2) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (rb == 32'd0) rb = 32'd1;
            run_op(2'b01, 1'b0, ra, rb, ra % rb, ra / rb, 1'b0, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, beside the ALU. It is fed the same two register-file operands.
- Computes the MULTU/DIVU results into HI/LO and handles MTHI/MTLO writes.
- Drives HI/LO to the writeback mux for MFHI/MFLO.
- Control stalls the PC while busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request strobe, sampled on rising clk edge
- op  input  2  00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO
- sgn  input  1  signed-operation select (see Optional Feature)
- a  input  WIDTH  operand A (rs): multiplicand, dividend, or MTHI/MTLO data
- b  input  WIDTH  operand B (rt): multiplier or divisor
- busy  output  1  high while MUL or DIV iterating
- done  output  1  one-cycle pulse when HI/LO hold the new result
- div_by_zero  output  1  valid with done; set only for DIVU with b==0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset, asynchronous, active-high: state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, iteration counter=0.
- Reset mid-operation aborts the operation; no done pulse is issued.
- States:
  - IDLE: accepts start.
  - MUL, DIV: iterate.
  - FIN: commit results, pulse done.
- IDLE + start:
  - op=00: latch a, b into internal registers; counter=0; go to MUL; busy=1 from the next cycle.
  - op=01: as op=00, but go to DIV.
  - op=10: hi<=a at that edge; lo unchanged; done=1 next cycle; busy stays 0; state stays IDLE.
  - op=11: lo<=a, same timing as op=10.
- MUL: shift-add, one multiplier bit per cycle. 2*WIDTH-bit accumulator; no overflow; result is the full 64-bit unsigned product.
- DIV: restoring division, one quotient bit per cycle. Quotient goes to LO, remainder to HI.
- MUL/DIV exit: after WIDTH iterations (counter==WIDTH-1), go to FIN.
- FIN: write hi/lo, done=1, busy=0, return to IDLE.
- Latency: start sampled at edge 0; done is high in the cycle after edge WIDTH+1 (33 edges for WIDTH=32). hi/lo change on the same edge that raises done.
- Divide by zero: the iteration still runs the full WIDTH cycles. Result hi=a, lo=all ones, div_by_zero=1 with done.
- div_by_zero clears on the next done and on reset.
- start while busy: ignored. No queueing, no effect on the operation in flight.
- start in the FIN cycle: ignored. Accepted again from IDLE.
- Operands latched at start; a and b may change freely while busy.
- hi/lo hold their values between operations. They are never modified during iteration, so MFHI/MFLO issued while busy read the old values.
- The internal counter wraps only via the FIN→IDLE reset to 0; it never exceeds WIDTH-1.

Optional Feature:
- Macro: MDU_SIGNED_EN.
- Defined:
  - sgn=1 with op=00/01 performs MULT/DIV.
  - Operands are converted to magnitudes at start. The iteration is unchanged.
  - FIN negates the product if signs differ.
  - Quotient is negated if signs differ; remainder takes the dividend's sign.
  - Divide by zero gives the same hi=a, lo=all ones result as the unsigned case.
  - Latency unchanged.
- Not defined: sgn is ignored; all operations are unsigned. The port stays in the list and is left unconnected internally.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> 33 edges later done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 32 cycles.
- DIVU a=100, b=7 -> lo=14, hi=2, div_by_zero=0. Then DIVU a=5, b=0 -> hi=5, lo=0xFFFFFFFF, div_by_zero=1.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 -> each gives a one-cycle done with busy=0; hi=0x12345678, lo=0x9ABCDEF0.
- MULTU 3*4 with start re-pulsed as DIVU 9/3 at cycle 5 -> second start ignored; hi=0, lo=12; only one done pulse.
- DIVU 100/7 with rst asserted asynchronously mid-cycle at cycle 10 -> busy, hi, lo immediately 0; no done pulse. A new MULTU 2*3 afterwards gives lo=6.
- With MDU_SIGNED_EN, sgn=1:
  - DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - Without the macro, the same DIV stimulus gives the unsigned result.
